// File: rtl/nmp_pkg.sv
// Shared constants and state encoding for the near-memory matrix-add engine.
// Also imported by the AXI4-Lite register block.
package nmp_pkg;

    localparam int DATA_W   = 32;
    localparam int MEM_SIZE = 512;
    localparam int ADDR_W   = $clog2(MEM_SIZE);
    localparam int SIZE_W   = 5;
    localparam int CNT_W    = 2 * SIZE_W;
    localparam int A_BASE   = 0;
    localparam int B_BASE   = MEM_SIZE / 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/nmp_addr_gen.sv
// Element counter, A/B read addresses and the 2-deep write-address delay line
// that keeps the write address aligned with the registered sum.
module nmp_addr_gen
    import nmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              rd_last,
    output logic              pre_v,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_last
);

    logic [ADDR_W-1:0] k;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_last;

    assign rd_last = rd_en && (CNT_W'(k) == cnt_q - CNT_W'(1));
    assign a_addr  = ADDR_W'(A_BASE) + k;
    // B address is forced to zero whenever the engine is not reading
    assign b_addr  = rd_en ? ADDR_W'(B_BASE) + k : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en <= 1'b0;
            k     <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rd_en <= 1'b1;
            k     <= '0;
            cnt_q <= count;
        end else if (rd_last) begin
            rd_en <= 1'b0;
            k     <= '0;
        end else if (rd_en) begin
            k <= k + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_v   <= 1'b0;
            s1_addr <= '0;
            s1_last <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_last <= 1'b0;
        end else begin
            pre_v   <= rd_en;
            s1_addr <= a_addr;
            s1_last <= rd_last;
            wr_en   <= pre_v;
            wr_addr <= s1_addr;
            wr_last <= s1_last;
        end
    end

endmodule

// File: rtl/nmp_matadd_engine.sv
// Streams A[k]+B[k] out of the shared BRAM and writes each sum back to A[k],
// one element per cycle, with size check and sticky overflow flag.
module nmp_matadd_engine
    import nmp_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic              r_wr_en,
    output logic [ADDR_W-1:0] r_wr_addr,
    output logic [DATA_W-1:0] r_wr_data
);

    state_t            state;
    logic [SIZE_W-1:0] size_q;
    logic [CNT_W-1:0]  count;
    logic              legal;
    logic              start;
    logic              accept;
    logic              rd_en;
    logic              rd_last;
    logic              pre_v;
    logic              wr_last;
    logic [DATA_W:0]   sum_full;

    assign accept   = cmd_valid && cmd_ready;
    assign count    = CNT_W'(size_q) * CNT_W'(size_q);
    assign legal    = (size_q != '0) && (count <= CNT_W'(B_BASE));
    assign start    = (state == CHECK) && legal;
    assign sum_full = {1'b0, a_rd_data} + {1'b0, b_rd_data};
    assign a_rd_en  = rd_en;
    assign b_rd_en  = rd_en;

    nmp_addr_gen u_addr_gen (
        .clk     (ACLK),
        .rst     (ARESET),
        .start   (start),
        .count   (count),
        .rd_en   (rd_en),
        .a_addr  (a_rd_addr),
        .b_addr  (b_rd_addr),
        .rd_last (rd_last),
        .pre_v   (pre_v),
        .wr_en   (r_wr_en),
        .wr_addr (r_wr_addr),
        .wr_last (wr_last)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_data <= '0;
        end else if (pre_v) begin
            r_wr_data <= sum_full[DATA_W-1:0];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            size_q    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (pre_v && sum_full[DATA_W]) begin
                ovf <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        size_q    <= cmd_size;
                        err       <= 1'b0;
                        ovf       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (legal) begin
                        state <= RUN;
                    end else begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                RUN: begin
                    if (rd_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // last write is on the port this cycle
                    if (r_wr_en && wr_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmp_matadd_engine.sv
// Randomised bench for nmp_matadd_engine with a 3-port BRAM model and a
// behavioural reference for sums, overflow, latency and access counts.
module tb_nmp_matadd_engine;

    localparam int HALF = 256;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [4:0]  cmd_size = '0;
    logic        cmd_ready, busy, done, err, ovf;
    logic        a_rd_en, b_rd_en, r_wr_en;
    logic [8:0]  a_rd_addr, b_rd_addr, r_wr_addr;
    logic [31:0] a_rd_data = '0;
    logic [31:0] b_rd_data = '0;
    logic [31:0] r_wr_data;

    logic [31:0] mem      [512];
    logic [31:0] init_mem [512];
    logic [31:0] exp_mem  [512];
    logic        load = 1'b0;
    int          ra_cnt = 0;
    int          rb_cnt = 0;
    int          wr_cnt = 0;

    int  checks = 0;
    int  errors = 0;
    int  rd_idx = 0;
    int  exp_m = 0;
    int  accepts = 0;
    int  cur_streak = 0;
    int  max_streak = 0;
    wr_t wq[$];

    nmp_matadd_engine dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_size  (cmd_size),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ovf       (ovf),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .b_rd_data (b_rd_data),
        .r_wr_en   (r_wr_en),
        .r_wr_addr (r_wr_addr),
        .r_wr_data (r_wr_data)
    );

    always #5 ACLK = ~ACLK;

    // BRAM: 1-cycle read latency on ports 0/1, write on port 2
    always @(posedge ACLK) begin
        if (load) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_mem[i];
        end else if (r_wr_en) begin
            mem[r_wr_addr] <= r_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (a_rd_en) begin
            a_rd_data <= mem[a_rd_addr];
            ra_cnt <= ra_cnt + 1;
        end
        if (b_rd_en) begin
            b_rd_data <= mem[b_rd_addr];
            rb_cnt <= rb_cnt + 1;
        end
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        bit acc;
        wr_t w;
        acc = cmd_valid && cmd_ready && !ARESET;
        @(posedge ACLK);
        #1;
        if (acc) begin
            rd_idx = 0;
            accepts++;
        end
        chk("ready_vs_busy", cmd_ready, !busy);
        if (a_rd_en || b_rd_en) begin
            chk("rd_pair", {a_rd_en, b_rd_en}, 2'b11);
            chk("rd_in_range", rd_idx < exp_m, 1);
            chk("a_addr", a_rd_addr, rd_idx);
            chk("b_addr", b_rd_addr, HALF + rd_idx);
            rd_idx++;
        end
        if (r_wr_en) begin
            cur_streak++;
            chk("write_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_addr", r_wr_addr, w.addr);
                chk("wr_data", r_wr_data, w.data);
            end
        end else begin
            cur_streak = 0;
        end
        if (cur_streak > max_streak) max_streak = cur_streak;
    endtask

    task automatic load_mem();
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return $urandom;
    endfunction

    // Reference: builds the expected write stream and final memory image
    function automatic bit build_model(input int n, output int m);
        logic [32:0] s;
        bit o;
        o = 0;
        m = n * n;
        if (n == 0 || m > HALF) m = 0;
        wq.delete();
        for (int i = 0; i < 512; i++) exp_mem[i] = mem[i];
        for (int k = 0; k < m; k++) begin
            s = {1'b0, mem[k]} + {1'b0, mem[HALF + k]};
            exp_mem[k] = s[31:0];
            wq.push_back(wr_t'{addr: 9'(k), data: s[31:0]});
            o |= s[32];
        end
        return o;
    endfunction

    function automatic int mem_diffs();
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== exp_mem[i]) bad++;
        return bad;
    endfunction

    task automatic run_cmd(input int n, input bit hold);
        int m, lat, ready_seen, ra0, rb0, wr0, acc0;
        bit exp_ovf, legal;
        exp_ovf = build_model(n, m);
        legal = (m != 0);
        exp_m = m;
        ra0 = ra_cnt;
        rb0 = rb_cnt;
        wr0 = wr_cnt;
        acc0 = accepts;
        max_streak = 0;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_size = 5'(n);
        tick();
        if (!hold) cmd_valid = 1'b0;
        chk("busy_on_accept", busy, 1);
        chk("err_cleared", err, 0);
        chk("ovf_cleared", ovf, 0);
        lat = 1;
        ready_seen = 0;
        while (!done && lat < 400) begin
            tick();
            lat++;
            if (cmd_ready) ready_seen++;
        end
        cmd_valid = 1'b0;
        chk("latency", lat, legal ? m + 4 : 2);
        chk("done", done, 1);
        chk("busy_at_done", busy, 1);
        chk("err", err, !legal);
        chk("ovf", ovf, exp_ovf);
        chk("ready_low_while_busy", ready_seen, 0);
        tick();
        chk("done_one_cycle", done, 0);
        tick();
        tick();
        chk("accept_count", accepts - acc0, 1);
        chk("idle", {cmd_ready, busy}, 2'b10);
        chk("err_held", err, !legal);
        chk("wq_empty", wq.size(), 0);
        chk("writes", wr_cnt - wr0, m);
        chk("reads_a", ra_cnt - ra0, m);
        chk("reads_b", rb_cnt - rb0, m);
        chk("mem_image", mem_diffs(), 0);
    endtask

    task automatic linear_pattern();
        for (int i = 0; i < HALF; i++) begin
            init_mem[i] = 32'(i);
            init_mem[HALF + i] = 32'(2 * i);
        end
        load_mem();
    endtask

    task automatic reset_outputs_check();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_flags", {busy, done, err, ovf}, 4'b0000);
        chk("rst_enables", {a_rd_en, b_rd_en, r_wr_en}, 3'b000);
        chk("rst_a_addr", a_rd_addr, 0);
        chk("rst_b_addr", b_rd_addr, 0);
        chk("rst_w_addr", r_wr_addr, 0);
        chk("rst_w_data", r_wr_data, 0);
    endtask

    task automatic reset_mid_run();
        int m, snap, wr0, found;
        bit unused_ovf;
        linear_pattern();
        unused_ovf = build_model(8, m);
        for (int i = 4; i < HALF; i++) exp_mem[i] = mem[i];
        exp_m = m;
        wr0 = wr_cnt;
        cmd_valid = 1'b1;
        cmd_size = 5'd8;
        tick();
        cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            tick();
            if (a_rd_en && a_rd_addr == 9'd5) found = 1;
        end
        chk("found_k5", found, 1);
        ARESET = 1'b1;
        tick();
        reset_outputs_check();
        ARESET = 1'b0;
        wq.delete();
        exp_m = 0;
        snap = wr_cnt;
        repeat (10) tick();
        chk("no_write_after_reset", wr_cnt - snap, 0);
        chk("writes_before_reset", snap - wr0, 4);
        chk("partial_image", mem_diffs(), 0);
        chk("idle_after_reset", {cmd_ready, busy}, 2'b10);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) init_mem[i] = '0;
        repeat (3) tick();
        reset_outputs_check();
        ARESET = 1'b0;
        tick();
        reset_outputs_check();

        linear_pattern();
        run_cmd(4, 0);
        chk("lit_a5", mem[5], 32'd15);
        chk("lit_a15", mem[15], 32'd45);
        chk("lit_a16_untouched", mem[16], 32'd16);

        linear_pattern();
        run_cmd(16, 0);
        chk("lit_a255", mem[255], 32'd765);
        chk("streak_256", max_streak, 256);

        run_cmd(0, 0);
        run_cmd(17, 0);

        init_mem[0] = 32'hFFFF_FFFF;
        init_mem[HALF] = 32'd1;
        load_mem();
        run_cmd(1, 0);
        chk("lit_wrap", mem[0], 32'd0);
        chk("lit_ovf_sticky", ovf, 1);

        init_mem[0] = 32'd5;
        init_mem[HALF] = 32'd6;
        load_mem();
        run_cmd(1, 0);
        chk("lit_sum11", mem[0], 32'd11);
        chk("lit_ovf_clear", ovf, 0);

        linear_pattern();
        run_cmd(8, 1);

        reset_mid_run();

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 512; i++) init_mem[i] = rnd_word();
            load_mem();
            run_cmd($urandom_range(0, 17), $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
